tb_harness_ctrl: RTL and testbench
==================================

// Module: tb_harness_ctrl
// PURPOSE
// - Multi-channel simulation harness controller; sits in the bench top between the free-running
//   clock/reset and NUM_CH instances of the v core.
// - Generates a staggered, synchronously released reset per UUT channel.
// - Counts run cycles, aggregates per-channel done/fail status and enforces a watchdog timeout.
// - Reports a single finished/pass/fail/timeout verdict to the bench.
// PARAMETERS
// - NUM_CH      4       number of UUT channels (1..16)
// - RST_CYCLES  16      cycles channel 0 is held in reset after start (>=1)
// - STAGGER     2       extra reset cycles per channel index (ch k releases at RST_CYCLES+k*STAGGER)
// - CNT_W       32      width of run-cycle counter
// - TIMEOUT     100000  run cycles before watchdog fires (< 2**CNT_W)
// PORTS
// - clk          in   1            bench clock
// - rst          in   1            asynchronous, active-low reset
// - start_i      in   1            single-cycle pulse; begins a test run (accepted in IDLE or DONE)
// - ch_done_i    in   NUM_CH       per-channel done level/pulse from UUTs
// - ch_fail_i    in   NUM_CH       per-channel fail level/pulse from UUTs
// - uut_rst_o    out  NUM_CH       active-high synchronous reset to each v instance
// - state_o      out  2            current FSM state (tb_pkg::state_t)
// - cycles_o     out  CNT_W        run cycles elapsed in RUN, saturating
// - done_mask_o  out  NUM_CH       sticky per-channel done
// - finished_o   out  1            high in DONE
// - pass_o       out  1            all channels done, none failed (valid when finished_o)
// - fail_o       out  1            any channel failed (valid when finished_o)
// - timeout_o    out  1            watchdog expired (valid when finished_o)
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state IDLE; uut_rst_o all 1 immediately.
//   - cycles_o, done_mask_o, finished_o, pass_o, fail_o, timeout_o all 0.
// - IDLE: uut_rst_o all 1; start_i -> RESET next cycle, rst_cnt=0.
// - RESET:
//   - rst_cnt increments each cycle.
//   - uut_rst_o[k] deasserts on the cycle after rst_cnt == RST_CYCLES+k*STAGGER-1, and stays low.
//   - When the last channel releases -> RUN. Total RESET duration = RST_CYCLES+(NUM_CH-1)*STAGGER.
// - RUN:
//   - cycles_o increments by 1 per cycle starting at 0 on entry; saturates at 2**CNT_W-1.
// - Status capture (RESET and RUN):
//   - ch_done_i[k]/ch_fail_i[k] are sampled only while uut_rst_o[k]==0; ignored otherwise.
//   - Captured bits are sticky until next start.
// - Exit RUN -> DONE, evaluated on sticky values including the current cycle's inputs:
//   - priority fail > all-done > timeout.
//   - any fail: fail_o=1, pass_o=0, timeout_o=0.
//   - else all done_mask bits set: pass_o=1.
//   - else cycles_o==TIMEOUT-1: timeout_o=1, pass_o=0.
//   - Simultaneous last-done and timeout -> pass. Simultaneous fail and timeout -> fail only.
//   - A fail captured during RESET ends the run on the first RUN cycle.
// - DONE:
//   - finished_o=1; verdict and cycles_o held.
//   - uut_rst_o held low (UUT state inspectable).
//   - start_i -> RESET: clears done_mask, verdict and cycles; reasserts all uut_rst_o that same cycle.
// - start_i in RESET/RUN is ignored. Exactly one of pass/fail/timeout is high in DONE.
// - Latency: start_i to first uut_rst_o deassert = RST_CYCLES+1 cycles.
// STRUCTURE
// - tb_pkg: state_t enum {IDLE=2'd0, RESET=2'd1, RUN=2'd2, DONE=2'd3}; verdict priority constants.
// - Sub-module tb_rst_stagger (NUM_CH, RST_CYCLES, STAGGER):
//   - rst_cnt plus per-channel release flops.
//   - Outputs uut_rst_o and all_released.
// - Top holds FSM, run counter, sticky masks and verdict regs.
// TESTING
// - NUM_CH=4,RST_CYCLES=16,STAGGER=2; start at cycle 0:
//   - uut_rst_o[0..3] fall at cycles 17/19/21/23; RUN entered cycle 23.
// - Pass: all ch_done_i pulse by RUN cycle 50 -> DONE, pass_o=1, cycles_o=50, fail_o=timeout_o=0.
// - Fail: ch_fail_i[2] pulse at RUN cycle 10, others never done -> DONE next cycle, fail_o=1.
// - Timeout (TIMEOUT=64): no done -> DONE after cycles_o==63; timeout_o=1.
//   - Rerun with last done on cycle 63: pass_o=1 instead.
// - Early status: ch_done_i[0] high from cycle 18 (released), ch_done_i[3] pulse at 20 (in reset):
//   - done_mask_o=4'b0001 on RUN entry.
// - rst low mid-RUN: uut_rst_o all 1 same cycle, state_o=IDLE, outputs 0.
//   - start after release replays first scenario exactly.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared types for the multi-channel harness controller: FSM state encoding and
// run verdict, plus the helper that ranks simultaneous end-of-run conditions.
package tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    V_NONE    = 2'd0,
    V_FAIL    = 2'd1,
    V_PASS    = 2'd2,
    V_TIMEOUT = 2'd3
  } verdict_t;

  // Fail outranks all-done, which outranks the watchdog.
  function automatic verdict_t pick_verdict(input logic any_fail,
                                            input logic all_done,
                                            input logic expired);
    verdict_t v;
    if (any_fail) begin
      v = V_FAIL;
    end else if (all_done) begin
      v = V_PASS;
    end else if (expired) begin
      v = V_TIMEOUT;
    end else begin
      v = V_NONE;
    end
    return v;
  endfunction

endpackage

// File: rtl/tb_rst_stagger.sv
// Staggered per-channel reset generator: channel k is released RST_CYCLES+k*STAGGER
// cycles after load, and stays released until the next load.
module tb_rst_stagger #(
  parameter int NUM_CH     = 4,
  parameter int RST_CYCLES = 16,
  parameter int STAGGER    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              active,
  output logic [NUM_CH-1:0] uut_rst,
  output logic              all_released
);

  localparam int LAST = RST_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int CW   = $clog2(LAST + 1);

  logic [CW-1:0]     rst_cnt_r;
  logic [NUM_CH-1:0] uut_rst_r;
  logic [NUM_CH-1:0] hit_s;

  // per-channel release match on the shared counter
  always_comb begin
    hit_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit_s[k] = (rst_cnt_r == CW'(RST_CYCLES + k * STAGGER - 1));
    end
  end

  // high in the cycle whose edge releases the last channel, so the FSM enters RUN with it
  assign all_released = active & hit_s[NUM_CH-1];
  assign uut_rst      = uut_rst_r;

  // reset counter and sticky release flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_cnt_r <= '0;
      uut_rst_r <= '1;
    end else if (load) begin
      rst_cnt_r <= '0;
      uut_rst_r <= '1;
    end else if (active) begin
      rst_cnt_r <= rst_cnt_r + CW'(1'b1);
      uut_rst_r <= uut_rst_r & ~hit_s;
    end else begin
      rst_cnt_r <= rst_cnt_r;
      uut_rst_r <= uut_rst_r;
    end
  end

endmodule

// File: rtl/tb_harness_ctrl.sv
// Harness controller: sequences channel resets, counts run cycles, collects sticky
// per-channel done/fail status and reports one finished verdict with a watchdog.
module tb_harness_ctrl
  import tb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int RST_CYCLES = 16,
  parameter int STAGGER    = 2,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] ch_done_i,
  input  logic [NUM_CH-1:0] ch_fail_i,
  output logic [NUM_CH-1:0] uut_rst_o,
  output state_t            state_o,
  output logic [CNT_W-1:0]  cycles_o,
  output logic [NUM_CH-1:0] done_mask_o,
  output logic              finished_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o
);

  state_t            state_r;
  logic [CNT_W-1:0]  cycles_r;
  logic [NUM_CH-1:0] done_mask_r, fail_mask_r;
  logic [NUM_CH-1:0] done_next_s, fail_next_s, live_s;
  logic              finished_r, pass_r, fail_r, timeout_r;
  logic              load_s, active_s, all_released_s, expired_s;
  verdict_t          verdict_s;

  assign load_s   = start_i && ((state_r == IDLE) || (state_r == DONE));
  assign active_s = (state_r == RESET);

  tb_rst_stagger #(
    .NUM_CH     (NUM_CH),
    .RST_CYCLES (RST_CYCLES),
    .STAGGER    (STAGGER)
  ) u_stagger (
    .clk          (clk),
    .rst          (rst),
    .load         (load_s),
    .active       (active_s),
    .uut_rst      (uut_rst_o),
    .all_released (all_released_s)
  );

  // status from a channel still held in reset is meaningless and dropped
  assign live_s      = ~uut_rst_o;
  assign done_next_s = done_mask_r | (ch_done_i & live_s);
  assign fail_next_s = fail_mask_r | (ch_fail_i & live_s);
  assign expired_s   = (cycles_r == CNT_W'(TIMEOUT - 1));
  assign verdict_s   = pick_verdict(|fail_next_s, &done_next_s, expired_s);

  // run-control FSM with run counter, sticky masks and verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cycles_r    <= '0;
      done_mask_r <= '0;
      fail_mask_r <= '0;
      finished_r  <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r     <= RESET;
            cycles_r    <= '0;
            done_mask_r <= '0;
            fail_mask_r <= '0;
          end
        end
        RESET: begin
          done_mask_r <= done_next_s;
          fail_mask_r <= fail_next_s;
          if (all_released_s) begin
            state_r  <= RUN;
            cycles_r <= '0;
          end
        end
        RUN: begin
          done_mask_r <= done_next_s;
          fail_mask_r <= fail_next_s;
          if (verdict_s == V_NONE) begin
            if (cycles_r != {CNT_W{1'b1}}) begin
              cycles_r <= cycles_r + CNT_W'(1'b1);
            end
          end else begin
            state_r    <= DONE;
            finished_r <= 1'b1;
            pass_r     <= (verdict_s == V_PASS);
            fail_r     <= (verdict_s == V_FAIL);
            timeout_r  <= (verdict_s == V_TIMEOUT);
          end
        end
        DONE: begin
          if (load_s) begin
            state_r     <= RESET;
            cycles_r    <= '0;
            done_mask_r <= '0;
            fail_mask_r <= '0;
            finished_r  <= 1'b0;
            pass_r      <= 1'b0;
            fail_r      <= 1'b0;
            timeout_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign state_o     = state_r;
  assign cycles_o    = cycles_r;
  assign done_mask_o = done_mask_r;
  assign finished_o  = finished_r;
  assign pass_o      = pass_r;
  assign fail_o      = fail_r;
  assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_tb_harness_ctrl.sv
// Self-checking bench for tb_harness_ctrl: directed scenarios against fixed cycle
// numbers, plus randomized runs checked against a cycle-arithmetic reference model.
module tb_tb_harness_ctrl;
  import tb_pkg::*;

  localparam int N    = 4;
  localparam int R    = 16;
  localparam int S    = 2;
  localparam int CW   = 32;
  localparam int TO   = 64;
  localparam int MAXC = 96;
  localparam int RUN0 = R + 1 + (N - 1) * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [N-1:0]  ch_done_i, ch_fail_i, uut_rst_o, done_mask_o;
  state_t        state_o;
  logic [CW-1:0] cycles_o;
  logic          finished_o, pass_o, fail_o, timeout_o;

  int total  = 0;
  int passed = 0;

  // stimulus per cycle of a run (cycle 0 carries the start pulse) and observed trace
  logic [N-1:0]  sd[MAXC], sf[MAXC], orst[MAXC], omask[MAXC];
  logic          sst[MAXC];
  logic [1:0]    os[MAXC];
  logic [CW-1:0] ocyc[MAXC];
  logic [3:0]    oflag[MAXC];
  int            m_end, m_verd;

  always #5 clk = ~clk;

  tb_harness_ctrl #(
    .NUM_CH(N), .RST_CYCLES(R), .STAGGER(S), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ch_done_i(ch_done_i), .ch_fail_i(ch_fail_i),
    .uut_rst_o(uut_rst_o), .state_o(state_o), .cycles_o(cycles_o), .done_mask_o(done_mask_o),
    .finished_o(finished_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o)
  );

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      sd[c] = '0; sf[c] = '0; sst[c] = (c == 0);
    end
  endtask

  // plays one run from a posedge+1 alignment, recording outputs at each negedge
  task automatic run();
    for (int c = 0; c < MAXC; c++) begin
      start_i = sst[c]; ch_done_i = sd[c]; ch_fail_i = sf[c];
      @(negedge clk);
      os[c] = state_o; orst[c] = uut_rst_o; omask[c] = done_mask_o; ocyc[c] = cycles_o;
      oflag[c] = {finished_o, pass_o, fail_o, timeout_o};
      @(posedge clk); #1;
    end
    start_i = 1'b0; ch_done_i = '0; ch_fail_i = '0;
  endtask

  // a channel's status counts from its release cycle R+1+k*S onward
  function automatic logic [N-1:0] cap_done(input int upto);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++)
      for (int c = R + 1 + k * S; c <= upto; c++)
        if (sd[c][k]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [N-1:0] cap_fail(input int upto);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++)
      for (int c = R + 1 + k * S; c <= upto; c++)
        if (sf[c][k]) m[k] = 1'b1;
    return m;
  endfunction

  // last RUN cycle and verdict (0 fail, 1 pass, 2 timeout)
  task automatic model();
    m_end = MAXC; m_verd = -1;
    for (int c = RUN0; c < MAXC; c++) begin
      if (m_end == MAXC) begin
        if (|cap_fail(c))            begin m_end = c; m_verd = 0; end
        else if (&cap_done(c))       begin m_end = c; m_verd = 1; end
        else if (c - RUN0 == TO - 1) begin m_end = c; m_verd = 2; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; ch_done_i = '0; ch_fail_i = '0;
    #12;
    total++; if (uut_rst_o !== 4'hf) $display("FAIL reset_uut_rst got %h want f", uut_rst_o); else passed++;
    total++; if (state_o !== IDLE) $display("FAIL reset_state got %0d want 0", state_o); else passed++;
    total++; if (cycles_o !== 32'd0) $display("FAIL reset_cycles got %0d want 0", cycles_o); else passed++;
    total++; if (done_mask_o !== 4'h0) $display("FAIL reset_mask got %h want 0", done_mask_o); else passed++;
    total++; if ({finished_o, pass_o, fail_o, timeout_o} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {finished_o, pass_o, fail_o, timeout_o}); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    int fall[N];
    fall = '{17, 19, 21, 23};
    clear_stim();
    sd[RUN0 + 20] = 4'b0101;
    sd[RUN0 + 50] = 4'b1111;
    run();
    for (int c = 1; c <= 26; c++)
      for (int k = 0; k < N; k++) begin
        total++;
        if (orst[c][k] !== (c < fall[k]))
          $display("FAIL pass_uut_rst c=%0d ch=%0d got %b want %b", c, k, orst[c][k], (c < fall[k]));
        else passed++;
      end
    total++; if (os[22] !== RESET) $display("FAIL pass_state22 got %0d want 1", os[22]); else passed++;
    total++; if (os[23] !== RUN) $display("FAIL pass_state23 got %0d want 2", os[23]); else passed++;
    total++; if (os[73] !== RUN) $display("FAIL pass_state73 got %0d want 2", os[73]); else passed++;
    total++; if (os[74] !== DONE) $display("FAIL pass_state74 got %0d want 3", os[74]); else passed++;
    total++; if (ocyc[74] !== 32'd50) $display("FAIL pass_cycles got %0d want 50", ocyc[74]); else passed++;
    total++; if (oflag[74] !== 4'b1100) $display("FAIL pass_flags got %b want 1100", oflag[74]); else passed++;
    total++; if (omask[74] !== 4'hf) $display("FAIL pass_mask got %h want f", omask[74]); else passed++;
    total++; if (orst[90] !== 4'h0) $display("FAIL pass_uut_held got %h want 0", orst[90]); else passed++;
    total++; if (ocyc[90] !== 32'd50) $display("FAIL pass_cycles_held got %0d want 50", ocyc[90]); else passed++;
  endtask

  task automatic test_fail();
    clear_stim();
    sf[RUN0 + 10] = 4'b0100;
    run();
    total++; if (os[33] !== RUN || ocyc[33] !== 32'd10)
      $display("FAIL fail_pre state/cycles got %0d/%0d want 2/10", os[33], ocyc[33]); else passed++;
    total++; if (os[34] !== DONE) $display("FAIL fail_state got %0d want 3", os[34]); else passed++;
    total++; if (oflag[34] !== 4'b1010) $display("FAIL fail_flags got %b want 1010", oflag[34]); else passed++;
    total++; if (ocyc[34] !== 32'd10) $display("FAIL fail_cycles got %0d want 10", ocyc[34]); else passed++;
  endtask

  task automatic test_timeout();
    clear_stim();
    run();
    total++; if (os[86] !== RUN || ocyc[86] !== 32'd63)
      $display("FAIL tmo_pre state/cycles got %0d/%0d want 2/63", os[86], ocyc[86]); else passed++;
    total++; if (os[87] !== DONE || oflag[87] !== 4'b1001)
      $display("FAIL tmo_flags state/flags got %0d/%b want 3/1001", os[87], oflag[87]); else passed++;
    total++; if (ocyc[87] !== 32'd63) $display("FAIL tmo_cycles got %0d want 63", ocyc[87]); else passed++;
    clear_stim();
    sd[40] = 4'b0111;
    sd[86] = 4'b1000;
    run();
    total++; if (oflag[87] !== 4'b1100) $display("FAIL tmo_lastdone_flags got %b want 1100", oflag[87]); else passed++;
    total++; if (ocyc[87] !== 32'd63) $display("FAIL tmo_lastdone_cycles got %0d want 63", ocyc[87]); else passed++;
    clear_stim();
    sf[86] = 4'b0010;
    run();
    total++; if (oflag[87] !== 4'b1010) $display("FAIL tmo_fail_flags got %b want 1010", oflag[87]); else passed++;
  endtask

  task automatic test_early_status();
    clear_stim();
    for (int c = 18; c < MAXC; c++) sd[c][0] = 1'b1;
    sd[20][3] = 1'b1;
    sst[10] = 1'b1;
    run();
    total++; if (os[23] !== RUN) $display("FAIL early_state got %0d want 2", os[23]); else passed++;
    total++; if (omask[23] !== 4'b0001) $display("FAIL early_mask got %b want 0001", omask[23]); else passed++;
    clear_stim();
    sf[20][0] = 1'b1;
    sf[19][3] = 1'b1;
    run();
    total++; if (os[23] !== RUN || os[24] !== DONE)
      $display("FAIL early_fail_state got %0d,%0d want 2,3", os[23], os[24]); else passed++;
    total++; if (oflag[24] !== 4'b1010 || ocyc[24] !== 32'd0)
      $display("FAIL early_fail_verdict got %b/%0d want 1010/0", oflag[24], ocyc[24]); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int dd, ff;
      logic [1:0] est;
      logic [CW-1:0] ecyc;
      logic [3:0] efl;
      dd = $urandom_range(12, 120);
      ff = $urandom_range(150, 3000);
      clear_stim();
      for (int c = 0; c < MAXC; c++)
        for (int k = 0; k < N; k++) begin
          sd[c][k] = ($urandom_range(0, dd - 1) == 0);
          sf[c][k] = ($urandom_range(0, ff - 1) == 0);
        end
      sst[$urandom_range(1, RUN0)] = 1'b1;
      model();
      run();
      for (int c = 1; c < MAXC; c++) begin
        est  = (c < RUN0) ? 2'd1 : ((c <= m_end) ? 2'd2 : 2'd3);
        ecyc = (c < RUN0) ? '0 : ((c <= m_end) ? CW'(c - RUN0) : CW'(m_end - RUN0));
        efl  = (c > m_end) ? {1'b1, m_verd == 1, m_verd == 0, m_verd == 2} : 4'b0000;
        total++; if (os[c] !== est)
          $display("FAIL rand%0d_state c=%0d got %0d want %0d", it, c, os[c], est); else passed++;
        total++; if (ocyc[c] !== ecyc)
          $display("FAIL rand%0d_cycles c=%0d got %0d want %0d", it, c, ocyc[c], ecyc); else passed++;
        total++; if (oflag[c] !== efl)
          $display("FAIL rand%0d_flags c=%0d got %b want %b", it, c, oflag[c], efl); else passed++;
        total++; if (omask[c] !== cap_done((c - 1 < m_end) ? c - 1 : m_end))
          $display("FAIL rand%0d_mask c=%0d got %b want %b", it, c, omask[c],
                   cap_done((c - 1 < m_end) ? c - 1 : m_end)); else passed++;
        for (int k = 0; k < N; k++) begin
          total++; if (orst[c][k] !== (c < R + 1 + k * S))
            $display("FAIL rand%0d_uut_rst c=%0d ch=%0d got %b", it, c, k, orst[c][k]); else passed++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 40; c++) begin
      start_i = (c == 0);
      ch_done_i = (c == 30) ? 4'b0011 : 4'b0000;
      @(posedge clk); #1;
    end
    start_i = 1'b0; ch_done_i = '0;
    total++; if (state_o !== RUN || cycles_o !== 32'd17 || done_mask_o !== 4'b0011)
      $display("FAIL arst_pre got %0d/%0d/%b want 2/17/0011", state_o, cycles_o, done_mask_o); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (uut_rst_o !== 4'hf) $display("FAIL arst_uut_rst got %h want f", uut_rst_o); else passed++;
    total++; if (state_o !== IDLE) $display("FAIL arst_state got %0d want 0", state_o); else passed++;
    total++; if (cycles_o !== 32'd0 || done_mask_o !== 4'h0)
      $display("FAIL arst_counts got %0d/%h want 0/0", cycles_o, done_mask_o); else passed++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    test_pass();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_early_status();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
